// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select generation and load-use / flush hazard control.
// Tracks only register indices and control bits of instructions in EX and MEM.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_use_imm_b,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [1:0]            ex_fwd_a_sel,
    output logic [1:0]            ex_fwd_b_sel,
    output logic [1:0]            ex_fwd_st_sel,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    // WB is not tracked: the register file writes through in the same cycle.
    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_mr_q, ex_mr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [1:0]            a_sel_q, a_sel_d;
    logic [1:0]            b_sel_q, b_sel_d;
    logic [1:0]            st_sel_q, st_sel_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic       ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
    logic       issue;
    logic [1:0] fwd_rs1, fwd_rs2;

    // Producer matching; x0 never matches so it is never forwarded or stalled on.
    always_comb begin
        ex_hit_rs1  = ex_valid_q & ex_rw_q & (ex_rd_q == id_rs1) & (id_rs1 != '0) & id_rs1_used;
        ex_hit_rs2  = ex_valid_q & ex_rw_q & (ex_rd_q == id_rs2) & (id_rs2 != '0) & id_rs2_used;
        mem_hit_rs1 = mem_valid_q & mem_rw_q & (mem_rd_q == id_rs1) & (id_rs1 != '0) & id_rs1_used;
        mem_hit_rs2 = mem_valid_q & mem_rw_q & (mem_rd_q == id_rs2) & (id_rs2 != '0) & id_rs2_used;
        fwd_rs1     = ex_hit_rs1 ? SEL_EXM : (mem_hit_rs1 ? SEL_MWB : SEL_RF);
        fwd_rs2     = ex_hit_rs2 ? SEL_EXM : (mem_hit_rs2 ? SEL_MWB : SEL_RF);
        stall       = id_valid & ~flush & ex_mr_q & (ex_hit_rs1 | ex_hit_rs2);
        issue       = id_valid & ~stall & ~flush;
    end

    always_comb begin
        ex_valid_d  = issue;
        ex_rd_d     = issue ? id_rd : '0;
        ex_rw_d     = issue & id_reg_write;
        ex_mr_d     = issue & id_mem_read;
        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_rw_d    = ex_rw_q;
        a_sel_d     = issue ? fwd_rs1 : SEL_RF;
        b_sel_d     = issue ? (id_use_imm_b ? SEL_IMM : fwd_rs2) : SEL_RF;
        st_sel_d    = issue ? fwd_rs2 : SEL_RF;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // Saturating event counters.
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            a_sel_q     <= SEL_RF;
            b_sel_q     <= SEL_RF;
            st_sel_q    <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            st_sel_q    <= st_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_fwd_a_sel  = a_sel_q;
    assign ex_fwd_b_sel  = b_sel_q;
    assign ex_fwd_st_sel = st_sel_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; small counter width exercises saturation.
module tb_fwd_hazard_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_use_imm_b, flush;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          stall, ex_valid;
    logic [1:0]    ex_fwd_a_sel, ex_fwd_b_sel, ex_fwd_st_sel;
    logic [CW-1:0] stall_count, flush_count;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] exp_stall_cnt = '0;
    logic [CW-1:0] exp_flush_cnt = '0;

    fwd_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_use_imm_b(id_use_imm_b),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_fwd_a_sel(ex_fwd_a_sel),
        .ex_fwd_b_sel(ex_fwd_b_sel), .ex_fwd_st_sel(ex_fwd_st_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic r1u, input logic r2u, input logic [RW-1:0] rd,
                         input logic rw, input logic mr, input logic imm);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = r1u; id_rs2_used = r2u;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_use_imm_b = imm;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; idle();
        tick(); tick();
        rst = 1'b0;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        vectors++; if (ex_fwd_a_sel !== 2'b00) begin miscompares++; $display("FAIL reset_a_sel got=%b exp=00", ex_fwd_a_sel); end
        vectors++; if (ex_fwd_b_sel !== 2'b00) begin miscompares++; $display("FAIL reset_b_sel got=%b exp=00", ex_fwd_b_sel); end
        vectors++; if (ex_fwd_st_sel !== 2'b00) begin miscompares++; $display("FAIL reset_st_sel got=%b exp=00", ex_fwd_st_sel); end
        vectors++; if (stall_count !== 3'd0) begin miscompares++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_count); end
        vectors++; if (flush_count !== 3'd0) begin miscompares++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_count); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall got=%0b exp=0", stall); end
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_ex_valid got=%0b exp=1", ex_valid); end
        vectors++; if (ex_fwd_a_sel !== 2'b01) begin miscompares++; $display("FAIL b2b_a_sel got=%b exp=01", ex_fwd_a_sel); end
        vectors++; if (ex_fwd_b_sel !== 2'b00) begin miscompares++; $display("FAIL b2b_b_sel got=%b exp=00", ex_fwd_b_sel); end
        drain();
    endtask

    task automatic test_distance2();
        for (int v = 0; v < 2; v++) begin
            issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
            tick();
            issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
            tick();
            issue(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, (v == 1));
            tick();
            if (v == 0) begin
                vectors++; if (ex_fwd_b_sel !== 2'b10) begin miscompares++; $display("FAIL dist2_b_sel got=%b exp=10", ex_fwd_b_sel); end
            end else begin
                vectors++; if (ex_fwd_b_sel !== 2'b11) begin miscompares++; $display("FAIL dist2_imm_b_sel got=%b exp=11", ex_fwd_b_sel); end
            end
            vectors++; if (ex_fwd_st_sel !== 2'b10) begin miscompares++; $display("FAIL dist2_st_sel v=%0d got=%b exp=10", v, ex_fwd_st_sel); end
            vectors++; if (ex_fwd_a_sel !== 2'b00) begin miscompares++; $display("FAIL dist2_a_sel v=%0d got=%b exp=00", v, ex_fwd_a_sel); end
            drain();
        end
    endtask

    task automatic test_load_use();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got=%0b exp=1", stall); end
        exp_stall_cnt = 3'd1;
        tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got=%0b exp=0", ex_valid); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_len got=%0b exp=0", stall); end
        vectors++; if (stall_count !== exp_stall_cnt) begin miscompares++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_count, exp_stall_cnt); end
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL lu_ex_valid got=%0b exp=1", ex_valid); end
        vectors++; if (ex_fwd_a_sel !== 2'b10) begin miscompares++; $display("FAIL lu_a_sel got=%b exp=10", ex_fwd_a_sel); end
        drain();
    endtask

    task automatic test_x0_double();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall got=%0b exp=0", stall); end
        tick();
        vectors++; if (ex_fwd_a_sel !== 2'b00) begin miscompares++; $display("FAIL x0_a_sel got=%b exp=00", ex_fwd_a_sel); end
        drain();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (ex_fwd_a_sel !== 2'b01) begin miscompares++; $display("FAIL dbl_a_sel got=%b exp=01", ex_fwd_a_sel); end
        drain();
    endtask

    task automatic test_flush_vs_stall();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fl_stall got=%0b exp=0", stall); end
        exp_flush_cnt = 3'd1;
        tick();
        flush = 1'b0; idle();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_ex_valid got=%0b exp=0", ex_valid); end
        vectors++; if (flush_count !== exp_flush_cnt) begin miscompares++; $display("FAIL fl_flush_cnt got=%0d exp=%0d", flush_count, exp_flush_cnt); end
        vectors++; if (stall_count !== exp_stall_cnt) begin miscompares++; $display("FAIL fl_stall_cnt got=%0d exp=%0d", stall_count, exp_stall_cnt); end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
            tick();
            issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
            tick();
            if (exp_stall_cnt != 3'd7) exp_stall_cnt = exp_stall_cnt + 3'd1;
            tick();
            drain();
        end
        vectors++; if (stall_count !== exp_stall_cnt) begin miscompares++; $display("FAIL sat_stall_cnt got=%0d exp=%0d", stall_count, exp_stall_cnt); end
        flush = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (exp_flush_cnt != 3'd7) exp_flush_cnt = exp_flush_cnt + 3'd1;
        end
        flush = 1'b0;
        vectors++; if (flush_count !== exp_flush_cnt) begin miscompares++; $display("FAIL sat_flush_cnt got=%0d exp=%0d", flush_count, exp_flush_cnt); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rm_pre_stall got=%0b exp=1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rm_stall got=%0b exp=0", stall); end
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL rm_ex_valid got=%0b exp=0", ex_valid); end
        vectors++; if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_fwd_st_sel} !== 6'b0) begin
            miscompares++; $display("FAIL rm_sels got=%b/%b/%b exp=00/00/00", ex_fwd_a_sel, ex_fwd_b_sel, ex_fwd_st_sel); end
        vectors++; if (stall_count !== 3'd0) begin miscompares++; $display("FAIL rm_stall_cnt got=%0d exp=0", stall_count); end
        vectors++; if (flush_count !== 3'd0) begin miscompares++; $display("FAIL rm_flush_cnt got=%0d exp=0", flush_count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_x0_double();
        test_flush_vs_stall();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
